// File: rtl/mtimer_pkg.sv
// Shared definitions for the machine timer: register offsets, reset values, lane merge.
package mtimer_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  // Byte offsets within the 16-byte register window
  localparam logic [3:0] OFF_MTIME_LO    = 4'h0;
  localparam logic [3:0] OFF_MTIME_HI    = 4'h4;
  localparam logic [3:0] OFF_MTIMECMP_LO = 4'h8;
  localparam logic [3:0] OFF_MTIMECMP_HI = 4'hC;

  localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

  // Word select decoded from addr[3:2]
  typedef enum logic [1:0] {
    RegMtimeLo = 2'd0,
    RegMtimeHi = 2'd1,
    RegCmpLo   = 2'd2,
    RegCmpHi   = 2'd3
  } reg_sel_e;

  // Replace only the byte lanes whose enable is set
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  lane_en);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (lane_en[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/mtimer_if.sv
// Data-bus slave interface of the machine timer.
interface mtimer_if #(
  parameter int unsigned XLEN = 32
);

  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic [3:0]      be;
  logic            wr;
  logic            rd;
  logic [XLEN-1:0] rdata;
  logic            ack;
  logic            hit;

  modport master (
    output addr, wdata, be, wr, rd,
    input  rdata, ack, hit
  );

  modport slave (
    input  addr, wdata, be, wr, rd,
    output rdata, ack, hit
  );

endinterface

// File: rtl/mtimer_tick.sv
// Prescale counter: one tick every PRESCALE non-stopped cycles.
module mtimer_tick #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic stop,
  input  logic clear,
  output logic tick
);

  // With PRESCALE=1 the counter is a single bit stuck at zero, leaving tick = ~stop.
  localparam int unsigned CntW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(PRESCALE - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Tick decode and next count; stop freezes the count, clear restarts it.
  always_comb begin
    tick  = ~stop & (cnt_q == CntMax);
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (!stop) begin
      cnt_d = tick ? '0 : cnt_q + CntW'(1);
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mtimer.sv
// RISC-V machine timer: 64-bit mtime/mtimecmp on the data bus, registered timer request.
module mtimer
  import mtimer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int unsigned PRESCALE  = 1,
  parameter int unsigned XLEN      = XLEN_DEFAULT
) (
  input  logic     clk,
  input  logic     rst_n,
  mtimer_if.slave  bus,
  input  logic     stop,
  output logic     timer
);

  logic [63:0]     mtime_q, mtime_d;
  logic [63:0]     mtimecmp_q, mtimecmp_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            ack_q, ack_d;
  logic            timer_q, timer_d;

  logic        hit;
  logic        wr_en;
  logic        rd_en;
  logic        tick;
  logic        tick_clear;
  logic [31:0] wword;
  logic [31:0] rd_word;
  reg_sel_e    sel;

  assign hit     = (bus.addr[31:4] == BASE_ADDR[31:4]);
  assign bus.hit = hit;
  assign sel     = reg_sel_e'(bus.addr[3:2]);
  assign wword   = bus.wdata[31:0];
  assign wr_en   = bus.wr & hit;
  // A simultaneous rd and wr is handled as a write only.
  assign rd_en   = bus.rd & hit & ~bus.wr;
  assign tick_clear = wr_en & ((sel == RegMtimeLo) | (sel == RegMtimeHi));

  mtimer_tick #(
    .PRESCALE(PRESCALE)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .stop (stop),
    .clear(tick_clear),
    .tick (tick)
  );

  // Register-file update, read mux, ack and compare.
  always_comb begin
    mtime_d    = mtime_q + 64'(tick);
    mtimecmp_d = mtimecmp_q;
    rd_word    = '0;

    // An mtime write replaces the increment; the other word is left untouched.
    if (wr_en) begin
      unique case (sel)
        RegMtimeLo: mtime_d = {mtime_q[63:32], merge_lanes(mtime_q[31:0], wword, bus.be)};
        RegMtimeHi: mtime_d = {merge_lanes(mtime_q[63:32], wword, bus.be), mtime_q[31:0]};
        RegCmpLo:   mtimecmp_d = {mtimecmp_q[63:32],
                                  merge_lanes(mtimecmp_q[31:0], wword, bus.be)};
        RegCmpHi:   mtimecmp_d = {merge_lanes(mtimecmp_q[63:32], wword, bus.be),
                                  mtimecmp_q[31:0]};
      endcase
    end

    unique case (sel)
      RegMtimeLo: rd_word = mtime_q[31:0];
      RegMtimeHi: rd_word = mtime_q[63:32];
      RegCmpLo:   rd_word = mtimecmp_q[31:0];
      RegCmpHi:   rd_word = mtimecmp_q[63:32];
    endcase

    rdata_d = rd_en ? XLEN'(rd_word) : rdata_q;
    ack_d   = hit & (bus.wr | bus.rd);
    timer_d = (mtime_q >= mtimecmp_q);
  end

  // State registers with synchronous reset; an access in flight is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mtime_q    <= '0;
      mtimecmp_q <= MTIMECMP_RESET;
      rdata_q    <= '0;
      ack_q      <= 1'b0;
      timer_q    <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      rdata_q    <= rdata_d;
      ack_q      <= ack_d;
      timer_q    <= timer_d;
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.ack   = ack_q;
  assign timer     = timer_q;

endmodule

// File: tb/tb_mtimer.sv
// Scoreboard bench for mtimer: PRESCALE=1 and PRESCALE=4 instances share one stimulus bus.
module tb_mtimer;
  import mtimer_pkg::*;

  localparam logic [31:0] BASE = 32'h0200_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  be = 4'hF;
  logic        wr = 1'b0;
  logic        rd = 1'b0;
  int          tgt = 0;
  logic        stop1 = 1'b0;
  logic        stop4 = 1'b0;
  logic        timer1, timer4;

  always #5 clk = ~clk;

  mtimer_if #(.XLEN(32)) b1 ();
  mtimer_if #(.XLEN(32)) b4 ();

  assign b1.addr  = addr;
  assign b1.wdata = wdata;
  assign b1.be    = be;
  assign b1.wr    = wr & (tgt == 0);
  assign b1.rd    = rd & (tgt == 0);
  assign b4.addr  = addr;
  assign b4.wdata = wdata;
  assign b4.be    = be;
  assign b4.wr    = wr & (tgt == 1);
  assign b4.rd    = rd & (tgt == 1);

  mtimer #(.BASE_ADDR(BASE), .PRESCALE(1), .XLEN(32)) u1 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (b1),
    .stop (stop1),
    .timer(timer1)
  );

  mtimer #(.BASE_ADDR(BASE), .PRESCALE(4), .XLEN(32)) u4 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (b4),
    .stop (stop4),
    .timer(timer4)
  );

  typedef struct {
    logic [31:0] data;
    int          cyc;
    bit          is_rd;
  } exp_t;

  exp_t        q1[$];
  exp_t        q4[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  logic [31:0] last1 = '0;
  logic [31:0] last4 = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor for the PRESCALE=1 instance: every ack must match the head of its queue.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (b1.ack) begin
      if (q1.size() == 0) begin
        chk("u1 unexpected ack", 64'(b1.ack), 64'd0);
      end else begin
        e = q1.pop_front();
        chk("u1 ack cycle", 64'(cyc), 64'(e.cyc));
        chk(e.is_rd ? "u1 read data" : "u1 write-ack rdata", 64'(b1.rdata), 64'(e.data));
      end
    end else if (q1.size() != 0 && q1[0].cyc <= cyc) begin
      e = q1.pop_front();
      chk("u1 missing ack", 64'(b1.ack), 64'd1);
    end
  end

  // Monitor for the PRESCALE=4 instance.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (b4.ack) begin
      if (q4.size() == 0) begin
        chk("u4 unexpected ack", 64'(b4.ack), 64'd0);
      end else begin
        e = q4.pop_front();
        chk("u4 ack cycle", 64'(cyc), 64'(e.cyc));
        chk(e.is_rd ? "u4 read data" : "u4 write-ack rdata", 64'(b4.rdata), 64'(e.data));
      end
    end else if (q4.size() != 0 && q4[0].cyc <= cyc) begin
      e = q4.pop_front();
      chk("u4 missing ack", 64'(b4.ack), 64'd1);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle read strobe; the expected word is the value before the sampling edge.
  task automatic bus_rd(input int t, input logic [3:0] off, input logic [31:0] exp);
    exp_t e;
    tgt     = t;
    addr    = BASE | 32'(off);
    be      = 4'hF;
    wr      = 1'b0;
    rd      = 1'b1;
    e.data  = exp;
    e.cyc   = cyc + 1;
    e.is_rd = 1'b1;
    if (t == 0) begin
      q1.push_back(e);
      last1 = exp;
    end else begin
      q4.push_back(e);
      last4 = exp;
    end
    @(negedge clk);
    rd = 1'b0;
  endtask

  // One-cycle write strobe; its ack carries the previous read data unchanged.
  task automatic bus_wr(input int t, input logic [3:0] off, input logic [31:0] data,
                        input logic [3:0] lanes);
    exp_t e;
    tgt     = t;
    addr    = BASE | 32'(off);
    wdata   = data;
    be      = lanes;
    rd      = 1'b0;
    wr      = 1'b1;
    e.data  = (t == 0) ? last1 : last4;
    e.cyc   = cyc + 1;
    e.is_rd = 1'b0;
    if (t == 0) q1.push_back(e);
    else        q4.push_back(e);
    @(negedge clk);
    wr = 1'b0;
    be = 4'hF;
  endtask

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    chk("u1 reset rdata", 64'(b1.rdata), 64'd0);
    chk("u1 reset ack", 64'(b1.ack), 64'd0);
    chk("u1 reset timer", 64'(timer1), 64'd0);
    chk("u4 reset rdata", 64'(b4.rdata), 64'd0);
    chk("u4 reset timer", 64'(timer4), 64'd0);
    rst_n = 1'b1;
    idle(1);
    chk("u1 timer after reset", 64'(timer1), 64'd0);
    bus_rd(0, OFF_MTIME_LO, 32'd1);
    bus_rd(0, OFF_MTIMECMP_LO, 32'hFFFF_FFFF);
    bus_rd(0, OFF_MTIMECMP_HI, 32'hFFFF_FFFF);

    // Carry from the low into the high word
    bus_wr(0, OFF_MTIME_LO, 32'hFFFF_FFFE, 4'hF);
    bus_wr(0, OFF_MTIME_HI, 32'h0, 4'hF);
    idle(3);
    bus_rd(0, OFF_MTIME_LO, 32'h0000_0001);
    bus_rd(0, OFF_MTIME_HI, 32'h0000_0001);

    // Compare: rise one cycle after mtime reaches 100, fall one cycle after raising cmp
    bus_wr(0, OFF_MTIMECMP_HI, 32'h0, 4'hF);
    bus_wr(0, OFF_MTIMECMP_LO, 32'd100, 4'hF);
    bus_wr(0, OFF_MTIME_HI, 32'h0, 4'hF);
    bus_wr(0, OFF_MTIME_LO, 32'd90, 4'hF);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      chk($sformatf("u1 timer rise k=%0d", k), 64'(timer1), 64'(k >= 11));
    end
    bus_wr(0, OFF_MTIMECMP_LO, 32'd1000, 4'hF);
    chk("u1 timer before fall", 64'(timer1), 64'd1);
    idle(1);
    chk("u1 timer fall", 64'(timer1), 64'd0);

    // mtimecmp = 0 asserts timer from the cycle after the write
    bus_wr(0, OFF_MTIMECMP_LO, 32'd0, 4'hF);
    chk("u1 cmp0 same cycle", 64'(timer1), 64'd0);
    idle(1);
    chk("u1 cmp0 timer", 64'(timer1), 64'd1);
    bus_wr(0, OFF_MTIMECMP_HI, 32'hFFFF_FFFF, 4'hF);
    idle(2);
    chk("u1 cmp raised", 64'(timer1), 64'd0);

    // Partial-lane mtime write coincident with a tick
    bus_wr(0, OFF_MTIME_HI, 32'd5, 4'hF);
    bus_wr(0, OFF_MTIME_LO, 32'hAAAA_0000, 4'hF);
    bus_wr(0, OFF_MTIME_LO, 32'h1234_5678, 4'b0011);
    bus_rd(0, OFF_MTIME_LO, 32'hAAAA_5678);
    bus_rd(0, OFF_MTIME_HI, 32'd5);

    // PRESCALE=4: stop freezes mid-count, partial count survives
    bus_wr(1, OFF_MTIME_HI, 32'h0, 4'hF);
    bus_wr(1, OFF_MTIME_LO, 32'h0, 4'hF);
    idle(2);
    stop4 = 1'b1;
    idle(5);
    bus_rd(1, OFF_MTIME_LO, 32'd0);
    idle(4);
    stop4 = 1'b0;
    idle(1);
    bus_rd(1, OFF_MTIME_LO, 32'd0);
    bus_rd(1, OFF_MTIME_LO, 32'd1);
    idle(2);
    bus_rd(1, OFF_MTIME_LO, 32'd1);
    bus_rd(1, OFF_MTIME_LO, 32'd2);

    // Reset arriving with a read strobe drops the access
    bus_wr(0, OFF_MTIMECMP_HI, 32'h0, 4'hF);
    bus_wr(0, OFF_MTIMECMP_LO, 32'h0, 4'hF);
    idle(1);
    chk("u1 timer before reset", 64'(timer1), 64'd1);
    tgt   = 0;
    addr  = BASE | 32'(OFF_MTIME_LO);
    rd    = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    rd    = 1'b0;
    rst_n = 1'b1;
    last1 = '0;
    last4 = '0;
    chk("u1 ack dropped by reset", 64'(b1.ack), 64'd0);
    chk("u1 rdata after reset", 64'(b1.rdata), 64'd0);
    chk("u1 timer after mid reset", 64'(timer1), 64'd0);
    bus_rd(0, OFF_MTIME_LO, 32'd0);
    bus_rd(0, OFF_MTIMECMP_LO, 32'hFFFF_FFFF);

    idle(4);
    chk("u1 pending acks", 64'(q1.size()), 64'd0);
    chk("u4 pending acks", 64'(q4.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
